pipelined_adder_nbit: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor; successor to the team's 4-bit ripple adder.
- Splits the carry chain into STAGES registered slices so wide adds close timing.
- Adds a subtract mode, a valid/ready stream handshake with back-pressure, and result flags (carry, signed overflow, zero).
- Sits between operand sources and the ALU result mux.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_slice.sv | 31 +++
 rtl/pipelined_adder_nbit.sv | 154 +++++++++++++++
 tb/tb_pipelined_adder_nbit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared configuration for the pipelined adder/subtractor:
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   slice_width()          : bits handled by one pipeline slice
//   cfg_ok()               : legal (WIDTH, STAGES) combination, used by the
//                            top level as an elaboration-time check
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 4;

   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// Purely combinational SLICE-bit adder used as one stage of the pipelined
// carry chain.
//   i_a, i_b   : slice operands (B already inverted for subtraction)
//   i_cin      : carry into the slice LSB
//   o_sum      : slice sum
//   o_cout     : carry out of the slice MSB
//   o_msb_cin  : carry into the slice MSB (for signed overflow detection)
// -----------------------------------------------------------------------------
module adder_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] i_a,
   input  logic [SLICE-1:0] i_b,
   input  logic             i_cin,
   output logic [SLICE-1:0] o_sum,
   output logic             o_cout,
   output logic             o_msb_cin
);

   logic [SLICE:0] w_full;

   assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};
   assign o_sum  = w_full[SLICE-1:0];
   assign o_cout = w_full[SLICE];
   // The MSB sum bit is a ^ b ^ carry_in, so the carry into it falls out by
   // XOR-ing the operands back off; this holds for SLICE = 1 as well.
   assign o_msb_cin = i_a[SLICE-1] ^ i_b[SLICE-1] ^ w_full[SLICE-1];

endmodule

// File: rtl/pipelined_adder_nbit.sv
// -----------------------------------------------------------------------------
// pipelined_adder_nbit
// WIDTH-bit adder/subtractor whose carry chain is cut into STAGES registered
// slices. Operands for upper slices travel skewed alongside the computation,
// finished lower sum slices ride along, and a valid bit shifts with each beat.
// The whole pipe stalls together when the result is not taken downstream.
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = pipe may advance)
//   bus0, bus1           : operands A and B
//   carry_in             : carry into LSB (add mode only)
//   op_sub               : 1 = A - B, 0 = A + B + carry_in
//   out_valid / out_ready: result handshake
//   sum, carry_out       : result and MSB carry (subtract: 1 = no borrow)
//   overflow, zero       : signed overflow, result == 0 (gated by out_valid)
// -----------------------------------------------------------------------------
module pipelined_adder_nbit
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] bus0,
   input  logic [WIDTH-1:0] bus1,
   input  logic             carry_in,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int SLICE = slice_width(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
      $error("pipelined_adder_nbit: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
   end

   logic             w_advance;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin0;

   // Every stage moves together: the pipe may shift whenever the output
   // register is empty or is being emptied this cycle.
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   // Subtraction is A + ~B + 1; the external carry is ignored in that mode.
   assign w_b_eff = op_sub ? ~bus1 : bus1;
   assign w_cin0  = op_sub ? 1'b1 : carry_in;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      localparam int LO   = g * SLICE;      // first bit handled by this stage
      localparam int DONE = LO + SLICE;     // bits finished after this stage

      logic [WIDTH-LO-1:0] w_a_up;          // operand bits not yet consumed
      logic [WIDTH-LO-1:0] w_b_up;
      logic                w_valid_in;
      logic                w_cin;
      logic [SLICE-1:0]    w_sum;
      logic                w_cout;
      logic [DONE-1:0]     w_sum_next;

      logic                r_valid;
      logic                r_carry;
      logic [DONE-1:0]     r_sum;

      if (g == 0) begin : g_head
         assign w_a_up     = bus0;
         assign w_b_up     = w_b_eff;
         assign w_valid_in = in_valid;
         assign w_cin      = w_cin0;
         assign w_sum_next = w_sum;
      end else begin : g_tail
         assign w_a_up     = g_stage[g-1].g_fwd.r_a;
         assign w_b_up     = g_stage[g-1].g_fwd.r_b;
         assign w_valid_in = g_stage[g-1].r_valid;
         assign w_cin      = g_stage[g-1].r_carry;
         assign w_sum_next = {w_sum, g_stage[g-1].r_sum};
      end

      // NOTE: state registers use non-blocking assignments so every stage
      // samples its predecessor's pre-edge value, giving a true shift.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_valid <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
         end else if (w_advance) begin
            r_valid <= w_valid_in;
            r_carry <= w_cout;
            r_sum   <= w_sum_next;
         end
      end

      if (g == STAGES - 1) begin : g_last
         logic w_msb_cin;
         logic r_ovf;

         adder_slice #(.SLICE(SLICE)) u_slice (
            .i_a       (w_a_up[SLICE-1:0]),
            .i_b       (w_b_up[SLICE-1:0]),
            .i_cin     (w_cin),
            .o_sum     (w_sum),
            .o_cout    (w_cout),
            .o_msb_cin (w_msb_cin)
         );

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_ovf <= 1'b0;
            end else if (w_advance) begin
               r_ovf <= w_msb_cin ^ w_cout;
            end
         end
      end else begin : g_fwd
         logic                  w_msb_cin_unused;
         logic [WIDTH-DONE-1:0] r_a;
         logic [WIDTH-DONE-1:0] r_b;

         adder_slice #(.SLICE(SLICE)) u_slice (
            .i_a       (w_a_up[SLICE-1:0]),
            .i_b       (w_b_up[SLICE-1:0]),
            .i_cin     (w_cin),
            .o_sum     (w_sum),
            .o_cout    (w_cout),
            .o_msb_cin (w_msb_cin_unused)
         );

         // Skew registers: upper operand slices wait here for their carry.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_advance) begin
               r_a <= w_a_up[WIDTH-LO-1:SLICE];
               r_b <= w_b_up[WIDTH-LO-1:SLICE];
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].r_valid;
   assign sum       = g_stage[STAGES-1].r_sum;
   assign carry_out = g_stage[STAGES-1].r_carry;
   assign overflow  = g_stage[STAGES-1].g_last.r_ovf;
   assign zero      = out_valid && (sum == '0);

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder_nbit
// Four DUT configurations (4,1) (16,4) (32,8) (8,8) share one stimulus
// stream. A queue-based model per instance predicts in_ready, out_valid and
// every retired result from plain integer arithmetic; instance 1 (16,4) also
// gets literal expectations for the directed cases.
// -----------------------------------------------------------------------------
module tb_pipelined_adder_nbit;

   localparam int N     = 4;
   localparam int DEPTH = 16;
   localparam int W_TAB [N] = '{4, 16, 32, 8};
   localparam int S_TAB [N] = '{1, 4, 8, 8};

   typedef struct packed {
      logic [31:0] sum;
      logic        c;
      logic        ov;
      logic        z;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        op_sub = 1'b0;
   logic        carry_in = 1'b0;
   logic [31:0] a_src = '0;
   logic [31:0] b_src = '0;

   always #5 clk = ~clk;

   logic [N-1:0] dut_in_ready, dut_out_valid, dut_cout, dut_ovf, dut_zero;
   logic [31:0]  dut_sum [N];
   logic [3:0]   sum0;
   logic [15:0]  sum1;
   logic [31:0]  sum2;
   logic [7:0]   sum3;

   assign dut_sum[0] = {28'd0, sum0};
   assign dut_sum[1] = {16'd0, sum1};
   assign dut_sum[2] = sum2;
   assign dut_sum[3] = {24'd0, sum3};

   pipelined_adder_nbit #(.WIDTH(4), .STAGES(1)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready[0]),
      .bus0(a_src[3:0]), .bus1(b_src[3:0]), .carry_in(carry_in), .op_sub(op_sub),
      .out_valid(dut_out_valid[0]), .out_ready(out_ready), .sum(sum0),
      .carry_out(dut_cout[0]), .overflow(dut_ovf[0]), .zero(dut_zero[0]));

   pipelined_adder_nbit #(.WIDTH(16), .STAGES(4)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready[1]),
      .bus0(a_src[15:0]), .bus1(b_src[15:0]), .carry_in(carry_in), .op_sub(op_sub),
      .out_valid(dut_out_valid[1]), .out_ready(out_ready), .sum(sum1),
      .carry_out(dut_cout[1]), .overflow(dut_ovf[1]), .zero(dut_zero[1]));

   pipelined_adder_nbit #(.WIDTH(32), .STAGES(8)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready[2]),
      .bus0(a_src), .bus1(b_src), .carry_in(carry_in), .op_sub(op_sub),
      .out_valid(dut_out_valid[2]), .out_ready(out_ready), .sum(sum2),
      .carry_out(dut_cout[2]), .overflow(dut_ovf[2]), .zero(dut_zero[2]));

   pipelined_adder_nbit #(.WIDTH(8), .STAGES(8)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready[3]),
      .bus0(a_src[7:0]), .bus1(b_src[7:0]), .carry_in(carry_in), .op_sub(op_sub),
      .out_valid(dut_out_valid[3]), .out_ready(out_ready), .sum(sum3),
      .carry_out(dut_cout[3]), .overflow(dut_ovf[3]), .zero(dut_zero[3]));

   // Model state: per-instance FIFO of expected results, each stamped with
   // the number of pipe advances seen when it was accepted.
   res_t exp_q   [N][DEPTH];
   int   stamp_q [N][DEPTH];
   int   head    [N];
   int   cnt     [N];
   int   adv_cnt [N];
   int   acc     [N];

   int   checks = 0;
   int   errors = 0;

   logic snap_valid;
   logic snap_ready;
   res_t snap_res;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Result of A op B at width w, from signed/unsigned integer arithmetic.
   function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
      longint m, half, ua, ub, sa, sb, t, r;
      res_t   res;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'({32'd0, a}) & m;
      ub   = longint'({32'd0, b}) & m;
      sa   = (ua >= half) ? ua - (m + 1) : ua;
      sb   = (ub >= half) ? ub - (m + 1) : ub;
      if (sub) begin
         t     = ua - ub;
         res.c = (ua >= ub);
         r     = sa - sb;
      end else begin
         t     = ua + ub + longint'(cin);
         res.c = (t > m);
         r     = sa + sb + longint'(cin);
      end
      res.sum = 32'(t & m);
      res.ov  = (r < -half) || (r >= half);
      res.z   = ((t & m) == 0);
      return res;
   endfunction

   // One clock: compare all instances against the model just before the
   // edge, then update the model with what the edge will do.
   task automatic tick();
      #1;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            check($sformatf("reset_outputs[%0d]", i),
                  64'({dut_out_valid[i], dut_sum[i], dut_cout[i], dut_ovf[i], dut_zero[i]}), 64'd0);
            head[i] = 0; cnt[i] = 0; adv_cnt[i] = 0;
         end else begin
            logic exp_v, exp_rdy;
            exp_v   = (cnt[i] > 0) && (adv_cnt[i] - stamp_q[i][head[i]] >= S_TAB[i]);
            exp_rdy = !exp_v || out_ready;
            check($sformatf("in_ready[%0d]", i), 64'(dut_in_ready[i]), 64'(exp_rdy));
            check($sformatf("out_valid[%0d]", i), 64'(dut_out_valid[i]), 64'(exp_v));
            if (exp_v)
               check($sformatf("result[%0d]", i),
                     64'({dut_sum[i], dut_cout[i], dut_ovf[i], dut_zero[i]}), 64'(exp_q[i][head[i]]));
            else
               check($sformatf("zero_idle[%0d]", i), 64'(dut_zero[i]), 64'd0);
            if (i == 1) begin
               snap_valid = dut_out_valid[1];
               snap_ready = dut_in_ready[1];
               snap_res   = res_t'({dut_sum[1], dut_cout[1], dut_ovf[1], dut_zero[1]});
            end
            if (exp_v && out_ready) begin
               head[i] = (head[i] + 1) % DEPTH;
               cnt[i]--;
            end
            if (in_valid && exp_rdy && cnt[i] < DEPTH) begin
               exp_q[i][(head[i] + cnt[i]) % DEPTH]   = model(W_TAB[i], a_src, b_src, carry_in, op_sub);
               stamp_q[i][(head[i] + cnt[i]) % DEPTH] = adv_cnt[i];
               cnt[i]++;
               acc[i]++;
            end
            if (exp_rdy) adv_cnt[i]++;
         end
      end
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick();
   endtask

   // Single beat on an empty pipe; checks latency and literal result of (16,4).
   task automatic send_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input res_t lit);
      int n;
      drain();
      a_src = a; b_src = b; carry_in = cin; op_sub = sub; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!snap_valid && n < 20) begin
         tick();
         n++;
      end
      check({name, "_latency"}, 64'(n - 1), 64'd4);
      check({name, "_result"}, 64'(snap_res), 64'(lit));
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         head[i] = 0; cnt[i] = 0; adv_cnt[i] = 0; acc[i] = 0;
      end
      snap_valid = 1'b0; snap_ready = 1'b0; snap_res = '0;

      // Power-on reset, then release.
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Directed arithmetic cases: {sum, carry_out, overflow, zero}.
      send_one("add_wrap",  32'hFFFF, 32'h0001, 1'b0, 1'b0, res_t'{32'h0000, 1'b1, 1'b0, 1'b1});
      send_one("add_ovf",   32'h7FFF, 32'h0001, 1'b0, 1'b0, res_t'{32'h8000, 1'b0, 1'b1, 1'b0});
      send_one("add_cin",   32'h1234, 32'h4321, 1'b1, 1'b0, res_t'{32'h5556, 1'b0, 1'b0, 1'b0});
      send_one("sub_borrow",32'h0005, 32'h0007, 1'b1, 1'b1, res_t'{32'hFFFE, 1'b0, 1'b0, 1'b0});
      send_one("sub_ovf",   32'h8000, 32'h0001, 1'b0, 1'b1, res_t'{32'h7FFF, 1'b1, 1'b1, 1'b0});

      // Back-pressure: 8 beats A=i, B=0x100*i, out_ready low for cycles 5..7.
      begin
         int sent, got, stalls, c;
         drain();
         sent = 1; got = 0; stalls = 0; c = 0;
         while ((sent <= 8 || got < 8) && c < 60) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = (sent <= 8);
            a_src     = 32'(sent);
            b_src     = 32'(sent * 32'h100);
            op_sub    = 1'b0;
            carry_in  = 1'b0;
            tick();
            if (!snap_ready) stalls++;
            if (in_valid && snap_ready) sent++;
            if (snap_valid && out_ready) begin
               got++;
               check($sformatf("bp_order_%0d", got), 64'(snap_res.sum), 64'(got * 32'h101));
            end
            c++;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         check("bp_count", 64'(got), 64'd8);
         check("bp_stall_cycles", 64'(stalls), 64'd3);
      end

      // Reset with three beats in flight: outputs clear at once, no strays.
      drain();
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; op_sub = 1'b0; carry_in = 1'b0;
         a_src = $urandom; b_src = $urandom;
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("rst_no_stray_%0d", k), 64'(snap_valid), 64'd0);
      end

      // Random sweep: at least 1000 beats into every configuration.
      for (int i = 0; i < N; i++) acc[i] = 0;
      begin
         int cyc;
         bit more;
         cyc  = 0;
         more = 1'b1;
         while (more && cyc < 6000) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 3) != 0);
            op_sub    = $urandom_range(0, 1) == 1;
            carry_in  = $urandom_range(0, 1) == 1;
            a_src     = $urandom;
            b_src     = $urandom;
            tick();
            cyc++;
            more = 1'b0;
            for (int i = 0; i < N; i++) if (acc[i] < 1000) more = 1'b1;
         end
         for (int i = 0; i < N; i++)
            check($sformatf("sweep_beats[%0d]", i), 64'(acc[i] >= 1000), 64'd1);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
